// File: rtl/cal_pkg.sv
// Shared definitions for the calibration EEPROM page writer:
// FSM state encoding, page geometry and the default write-cycle wait.
package cal_pkg;

  localparam int CAL_WORDS      = 8;
  localparam int CAL_PAGE_BYTES = 32;
  localparam int CAL_FRAME_BITS = CAL_WORDS * 32;

  // 5 ms EEPROM internal write cycle at a 50 MHz clock
  localparam int T_WR_DEFAULT   = 250000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_WR  = 3'd3,
    DONE     = 3'd4
  } cal_state_t;

endpackage

// File: rtl/cal_wr_timer.sv
// Down-counter used to wait out the EEPROM internal write cycle.
// clr beats load, load beats counting; the counter parks at zero.
module cal_wr_timer #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load / count-down register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count_en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cal_eeprom_writer.sv
// Writes one 32-byte calibration frame per page into an I2C EEPROM through
// a byte-write controller, then waits out the EEPROM write cycle. Pages are
// used round-robin; go aborts everything and rewinds to page 0.
module cal_eeprom_writer
  import cal_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          NUM_PAGES = 8,
  parameter int          T_WR      = T_WR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  input  logic                      frame_valid,
  input  logic [CAL_FRAME_BITS-1:0] frame_data,
  output logic                      frame_ready,
  output logic                      eep_wr_en,
  output logic [15:0]               eep_addr,
  output logic [7:0]                eep_wdata,
  input  logic                      eep_done,
  input  logic                      eep_err,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int TW = (T_WR > 1) ? $clog2(T_WR) : 1;
  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam logic [TW-1:0] WR_LOAD   = TW'(T_WR - 1);
  localparam logic [PW-1:0] LAST_PAGE = PW'(NUM_PAGES - 1);
  localparam logic [4:0]    LAST_BYTE = 5'(CAL_PAGE_BYTES - 1);

  cal_state_t                state;
  logic [CAL_FRAME_BITS-1:0] frame_q;
  logic [4:0]                byte_idx;
  logic [PW-1:0]             page_ptr;
  logic                      tmr_load;
  logic                      tmr_zero;
  logic [7:0]                page_bytes [CAL_PAGE_BYTES];

  // Byte select: data1 first, each word MSB byte first
  for (genvar gi = 0; gi < CAL_PAGE_BYTES; gi++) begin : g_bytes
    assign page_bytes[gi] = frame_q[CAL_FRAME_BITS-1-8*gi -: 8];
  end

  assign eep_wdata   = page_bytes[byte_idx];
  assign eep_addr    = BASE_ADDR + (16'(page_ptr) * 16'(CAL_PAGE_BYTES)) + {11'b0, byte_idx};
  assign frame_ready = (state == IDLE) && !go;
  assign busy        = (state != IDLE);

  // Last byte acknowledged cleanly: start the write-cycle wait
  assign tmr_load = (state == WAIT_ACK) && eep_done && !eep_err && (byte_idx == LAST_BYTE);

  cal_wr_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (go),
    .load     (tmr_load),
    .load_val (WR_LOAD),
    .count_en (state == WAIT_WR),
    .zero     (tmr_zero)
  );

  // Page-write FSM; eep_wr_en and done are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_q   <= '0;
      byte_idx  <= '0;
      page_ptr  <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      eep_wr_en <= 1'b0;
    end else if (go) begin
      state     <= IDLE;
      byte_idx  <= '0;
      page_ptr  <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      eep_wr_en <= 1'b0;
    end else begin
      eep_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_valid) begin
            frame_q   <= frame_data;
            byte_idx  <= '0;
            err       <= 1'b0;
            eep_wr_en <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: state <= WAIT_ACK;
        WAIT_ACK: begin
          if (eep_done) begin
            if (eep_err) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (byte_idx == LAST_BYTE) begin
              state <= WAIT_WR;
            end else begin
              byte_idx  <= byte_idx + 5'd1;
              eep_wr_en <= 1'b1;
              state     <= SEND;
            end
          end
        end
        WAIT_WR: begin
          if (tmr_zero) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          page_ptr <= (page_ptr == LAST_PAGE) ? '0 : page_ptr + PW'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_eeprom_writer.sv
// Directed bench for cal_eeprom_writer with a latency-3 byte controller model.
module tb_cal_eeprom_writer;

  localparam int          TWR  = 20;
  localparam int          NP   = 8;
  localparam logic [15:0] BASE = 16'h0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         go = 1'b0;
  logic         frame_valid = 1'b0;
  logic [255:0] frame_data = '0;
  logic         frame_ready;
  logic         eep_wr_en;
  logic [15:0]  eep_addr;
  logic [7:0]   eep_wdata;
  logic         eep_done = 1'b0;
  logic         eep_err = 1'b0;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  cal_eeprom_writer #(
    .BASE_ADDR (BASE),
    .NUM_PAGES (NP),
    .T_WR      (TWR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .eep_wr_en   (eep_wr_en),
    .eep_addr    (eep_addr),
    .eep_wdata   (eep_wdata),
    .eep_done    (eep_done),
    .eep_err     (eep_err),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte-controller model and output monitor (sampled 1 time unit after each edge)
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  int          wr_cyc [$];
  int          cyc = 0;
  int          pend = 0;
  bit          pend_err = 1'b0;
  int          err_byte = -1;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_ack_cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      eep_done = 1'b0;
      eep_err  = 1'b0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!busy) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          eep_done     = 1'b1;
          eep_err      = pend_err;
          last_ack_cyc = cyc;
        end
      end
      if (eep_wr_en) begin
        log_addr.push_back(eep_addr);
        log_data.push_back(eep_wdata);
        wr_cyc.push_back(cyc);
        pend     = 3;
        pend_err = (err_byte >= 0) && (eep_addr[4:0] == err_byte[4:0]);
      end
    end
  end

  // Frame handshake monitor on the falling edge
  int accept_cnt = 0;
  int accept_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && frame_valid && frame_ready) begin
        accept_cnt++;
        accept_cyc = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
  endtask

  task automatic send_frame(input logic [255:0] d, input string tag);
    int prev;
    prev = accept_cnt;
    frame_data  = d;
    frame_valid = 1'b1;
    for (int i = 0; i < 100 && accept_cnt == prev; i++) step();
    frame_valid = 1'b0;
    check({tag, "_accept"}, accept_cnt - prev, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    check({tag, "_idle"}, {31'b0, busy}, 0);
  endtask

  int base;
  int d0;
  int a0;
  logic [31:0] w;

  initial begin
    // reset values while rst_n is low
    step();
    step();
    check("rst_frame_ready", {31'b0, frame_ready}, 1);
    check("rst_wr_en",       {31'b0, eep_wr_en}, 0);
    check("rst_busy",        {31'b0, busy}, 0);
    check("rst_done",        {31'b0, done}, 0);
    check("rst_err",         {31'b0, err}, 0);
    check("rst_addr",        {16'b0, eep_addr}, 32'(BASE));
    check("rst_wdata",       {24'b0, eep_wdata}, 0);
    rst_n = 1'b1;
    step();
    step();

    // S1: words 1..8, page 0
    base = log_addr.size();
    d0   = done_cnt;
    send_frame({32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, "s1");
    wait_idle("s1");
    check("s1_count", log_addr.size() - base, 32);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("s1_addr%0d", i), {16'b0, log_addr[base+i]}, i);
      check($sformatf("s1_data%0d", i), {24'b0, log_data[base+i]}, (i % 4 == 3) ? (i / 4 + 1) : 0);
    end
    check("s1_done",     done_cnt - d0, 1);
    // ack cycle, then TWR wait cycles, then the done cycle
    check("s1_done_gap", done_cyc - last_ack_cyc, TWR + 1);
    // wr_en, 3-cycle ack latency, next wr_en with no idle cycle
    check("s1_span",     wr_cyc[base+31] - wr_cyc[base], 31 * 4);
    check("s1_err",      {31'b0, err}, 0);
    $display("s1 page write: bytes=%0d first_addr=0x%04h done_gap=%0d", log_addr.size() - base, log_addr[base], done_cyc - last_ack_cyc);

    // S2: rewind, then 9 frames -> the 9th lands on page 0 again
    pulse_go();
    d0 = done_cnt;
    for (int k = 0; k < 9; k++) begin
      base = log_addr.size();
      w = 32'h11223300 | 32'(k);
      send_frame({8{w}}, "s2");
      wait_idle("s2");
      check($sformatf("s2_f%0d_count", k), log_addr.size() - base, 32);
      check($sformatf("s2_f%0d_addr0", k), {16'b0, log_addr[base]}, (k % 8) * 32);
      check($sformatf("s2_f%0d_addr31", k), {16'b0, log_addr[base+31]}, (k % 8) * 32 + 31);
      check($sformatf("s2_f%0d_data0", k), {24'b0, log_data[base]}, 32'h11);
      check($sformatf("s2_f%0d_data31", k), {24'b0, log_data[base+31]}, k);
      $display("s2 frame %0d: first_addr=0x%04h", k, log_addr[base]);
    end
    check("s2_done", done_cnt - d0, 9);

    // S3: NACK on byte 5, then the same page is rewritten
    pulse_go();
    err_byte = 5;
    base = log_addr.size();
    d0   = done_cnt;
    send_frame({8{32'hCAFE0001}}, "s3a");
    wait_idle("s3a");
    err_byte = -1;
    check("s3_err",      {31'b0, err}, 1);
    check("s3_no_done",  done_cnt - d0, 0);
    check("s3_count",    log_addr.size() - base, 6);
    check("s3_last",     {16'b0, log_addr[log_addr.size()-1]}, 5);
    $display("s3 nacked page: bytes=%0d err=%0b", log_addr.size() - base, err);
    base = log_addr.size();
    send_frame({8{32'hCAFE0002}}, "s3b");
    check("s3_err_clr",  {31'b0, err}, 0);
    wait_idle("s3b");
    check("s3_re_addr0", {16'b0, log_addr[base]}, 0);
    check("s3_re_count", log_addr.size() - base, 32);
    check("s3_re_done",  done_cnt - d0, 1);
    $display("s3 rewrite: first_addr=0x%04h", log_addr[base]);

    // S4: go during the write-cycle wait of page 1
    base = log_addr.size();
    d0   = done_cnt;
    send_frame({8{32'h0BADF00D}}, "s4");
    for (int n = 0; n < 400 && (log_addr.size() - base) < 32; n++) step();
    check("s4_addr0", {16'b0, log_addr[base]}, 32);
    repeat (8) step();
    check("s4_busy_pre", {31'b0, busy}, 1);
    go = 1'b1;
    step();
    go = 1'b0;
    check("s4_busy",    {31'b0, busy}, 0);
    check("s4_addr",    {16'b0, eep_addr}, 32'(BASE));
    repeat (30) step();
    check("s4_no_done", done_cnt - d0, 0);
    check("s4_no_wr",   log_addr.size() - base, 32);
    $display("s4 abort in write wait: done_pulses=%0d", done_cnt - d0);

    // S5: reset during byte 12, then a fresh frame starts at byte 0
    base = log_addr.size();
    send_frame({8{32'h55AA55AA}}, "s5a");
    for (int n = 0; n < 200 && (log_addr.size() - base) < 13; n++) step();
    check("s5_addr12", {16'b0, log_addr[base+12]}, 12);
    rst_n = 1'b0;
    #1;
    check("s5_busy",  {31'b0, busy}, 0);
    check("s5_wr_en", {31'b0, eep_wr_en}, 0);
    check("s5_addr",  {16'b0, eep_addr}, 32'(BASE));
    check("s5_wdata", {24'b0, eep_wdata}, 0);
    check("s5_ready", {31'b0, frame_ready}, 1);
    check("s5_done",  {31'b0, done}, 0);
    check("s5_err",   {31'b0, err}, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    base = log_addr.size();
    d0   = done_cnt;
    send_frame({32'hDEADBEEF, 224'h0}, "s5b");
    wait_idle("s5b");
    check("s5_count",  log_addr.size() - base, 32);
    check("s5_addr0",  {16'b0, log_addr[base]}, 0);
    check("s5_data0",  {24'b0, log_data[base]}, 32'hDE);
    check("s5_data3",  {24'b0, log_data[base+3]}, 32'hEF);
    check("s5_data4",  {24'b0, log_data[base+4]}, 0);
    check("s5_re_done", done_cnt - d0, 1);
    $display("s5 after reset: first_addr=0x%04h first_byte=0x%02h", log_addr[base], log_data[base]);

    // S6: frame_valid held through a whole page
    d0 = done_cnt;
    a0 = accept_cnt;
    frame_data  = {8{32'h01020304}};
    frame_valid = 1'b1;
    for (int n = 0; n < 1000 && done_cnt == d0; n++) step();
    check("s6_one_accept", accept_cnt - a0, 1);
    for (int n = 0; n < 10 && (accept_cnt - a0) < 2; n++) step();
    check("s6_two_accept", accept_cnt - a0, 2);
    check("s6_order", {31'b0, accept_cyc > done_cyc}, 1);
    frame_valid = 1'b0;
    wait_idle("s6");
    check("s6_done", done_cnt - d0, 2);
    $display("s6 held valid: accepts=%0d done_pulses=%0d", accept_cnt - a0, done_cnt - d0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cal_eeprom_writer.md
CAL_EEPROM_WRITER -- requirements
Module: cal_eeprom_writer

Interface
REQ-001 Parameter BASE_ADDR, 16'h0000, EEPROM byte address of calibration page 0.
REQ-002 Parameter NUM_PAGES, 8, number of 32-byte calibration pages before the page pointer wraps to 0.
REQ-003 Parameter T_WR, 250000, EEPROM internal write-cycle wait in clk cycles (5 ms at 50 MHz).
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 go  in  1  synchronous clear/abort, same meaning as the cache-clear go.
REQ-007 frame_valid  in  1  calibration frame offered.
REQ-008 frame_data  in  256  eight 32-bit channel words; data1 = [255:224] ... data8 = [31:0].
REQ-009 frame_ready  out  1  frame accepted on frame_valid & frame_ready.
REQ-010 eep_wr_en  out  1  one-cycle byte-write request to the I2C byte controller.
REQ-011 eep_addr  out  16  byte address, valid while the request is outstanding.
REQ-012 eep_wdata  out  8  byte data, valid while the request is outstanding.
REQ-013 eep_done  in  1  one-cycle pulse: byte transfer finished.
REQ-014 eep_err  in  1  qualifies eep_done: slave NACK.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse after a page completes without error.
REQ-017 err  out  1  sticky error flag.

Function
REQ-018 The FSM SHALL have states IDLE, SEND, WAIT_ACK, WAIT_WR and DONE.
REQ-019 frame_ready SHALL be 1 only in IDLE with go low; on accept, the FSM SHALL latch frame_data, clear the byte index to 0 and clear err, then enter SEND on the next cycle.
REQ-020 SEND SHALL pulse eep_wr_en for exactly 1 cycle, then enter WAIT_ACK.
REQ-021 eep_addr SHALL equal BASE_ADDR + 32*page_ptr + byte_idx (16-bit, modulo 2^16).
REQ-022 Byte order SHALL be data1 first and each word MSB byte first: byte_idx n = latched[255-8n -: 8].
REQ-023 In WAIT_ACK, eep_done & !eep_err with byte_idx < 31 SHALL increment byte_idx and return to SEND; the per-byte gap SHALL be at most 1 idle cycle.
REQ-024 In WAIT_ACK, eep_done & !eep_err with byte_idx = 31 SHALL enter WAIT_WR and load the wait counter with T_WR-1.
REQ-025 WAIT_WR SHALL count down to 0, then enter DONE.
REQ-026 DONE SHALL pulse done for 1 cycle, advance page_ptr (NUM_PAGES-1 wraps to 0), and return to IDLE.
REQ-027 In WAIT_ACK, eep_done & eep_err SHALL set err, leave page_ptr unchanged, skip WAIT_WR and return directly to IDLE without a done pulse.
REQ-028 eep_done arriving outside WAIT_ACK SHALL be ignored.
REQ-029 go high SHALL, in any state and on the next edge, enter IDLE, clear page_ptr, byte_idx, err and the wait counter, and issue no further eep_wr_en pulse.
REQ-030 go has priority over eep_done and frame_valid in the same cycle.
REQ-031 frame_valid held while busy SHALL NOT be accepted until the FSM is back in IDLE.

Reset
REQ-032 While rst_n = 0, the block SHALL be in IDLE with frame_ready=1 and eep_wr_en, busy, done, err = 0.
REQ-033 While rst_n = 0, eep_addr SHALL be BASE_ADDR and eep_wdata, page_ptr, byte_idx and the counter SHALL be 0.
REQ-034 Reset asserted mid-page SHALL abandon the page; there is no resume.

Structure
REQ-035 The shared package cal_pkg SHALL hold the FSM state encoding, CAL_WORDS=8, CAL_PAGE_BYTES=32 and the default T_WR.
REQ-036 The page-address/byte-select logic SHALL be a combinational datapath inside the module.
REQ-037 The wait timer SHALL be the single sub-module cal_wr_timer (load, count, zero flag).

Verification
REQ-038 Scenario 1: frame 0x00000001..0x00000008 with an eep_done model at latency 3 and T_WR=20 -> 32 wr_en pulses at addresses 0x0000..0x001F; bytes 00 00 00 01 ... 00 00 00 08; done 20 cycles after the last ack.
REQ-039 Scenario 2: 9 consecutive frames with NUM_PAGES=8 -> page 8 written at 0x0000 again; 9 done pulses.
REQ-040 Scenario 3: eep_err on byte 5 -> err=1, no done, next frame rewrites the same page at 0x0000 and clears err.
REQ-041 Scenario 4: go pulse during WAIT_WR -> IDLE next cycle, no done, page_ptr=0.
REQ-042 Scenario 5: rst_n low during byte 12 -> all outputs at reset values immediately; a new frame restarts at byte 0.
REQ-043 Scenario 6: frame_valid held high for the whole page -> exactly one accept; a second accept occurs only after done.
